// File: rtl/core_pkg.sv
// core_pkg: shared types for the RV32I multi-cycle controller.
// Contents: controller state enum, RV32I major-opcode constants, datapath
// mux-select enums, the latched instruction class enum, and the opcode
// classifier used in DECODE.
package core_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_TRAP   = 3'd7
  } ctrl_state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'd0,   // pc + 4
    PC_REL   = 2'd1,   // pc + imm
    PC_JALR  = 2'd2    // (rs1 + imm) & ~1
  } pc_sel_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_e;

  typedef enum logic [3:0] {
    CL_R,
    CL_IMM,
    CL_LOAD,
    CL_STORE,
    CL_BRANCH,
    CL_JAL,
    CL_JALR,
    CL_AUIPC,
    CL_LUI,
    CL_SYSTEM,
    CL_ILLEGAL   // AMO, FENCE and anything not listed above
  } op_class_e;

  function automatic op_class_e classify(input logic [6:0] opcode);
    op_class_e cl;
    case (opcode)
      OP_R:      cl = CL_R;
      OP_IMM:    cl = CL_IMM;
      OP_LOAD:   cl = CL_LOAD;
      OP_STORE:  cl = CL_STORE;
      OP_BRANCH: cl = CL_BRANCH;
      OP_JAL:    cl = CL_JAL;
      OP_JALR:   cl = CL_JALR;
      OP_AUIPC:  cl = CL_AUIPC;
      OP_LUI:    cl = CL_LUI;
      OP_SYSTEM: cl = CL_SYSTEM;
      default:   cl = CL_ILLEGAL;
    endcase
    return cl;
  endfunction

endpackage

// File: rtl/core_ctrl_if.sv
// core_ctrl_if: instruction/data memory handshake bundle of the controller.
//   imem_req / imem_ack : instruction fetch request / acknowledge
//   dmem_req / dmem_ack : data access request / acknowledge
//   dmem_we             : data access is a store
// master = controller side, slave = memory side.
interface core_ctrl_if;
  logic imem_req;
  logic imem_ack;
  logic dmem_req;
  logic dmem_ack;
  logic dmem_we;

  modport master (
    output imem_req, dmem_req, dmem_we,
    input  imem_ack, dmem_ack
  );

  modport slave (
    input  imem_req, dmem_req, dmem_we,
    output imem_ack, dmem_ack
  );
endinterface

// File: rtl/core_ctrl_perf.sv
// core_ctrl_perf: cycle and retired-instruction counters for core_ctrl.
//   clk, rst_n   : clock, synchronous active-low reset
//   count_en     : controller is in an active state this cycle
//   retire       : controller pulses pc_we this cycle
//   cycle_cnt    : active-cycle count, wraps modulo 2^XLEN
//   instret_cnt  : retired-instruction count, wraps modulo 2^XLEN
module core_ctrl_perf #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            count_en,
  input  logic            retire,
  output logic [XLEN-1:0] cycle_cnt,
  output logic [XLEN-1:0] instret_cnt
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (count_en) cycle_cnt   <= cycle_cnt + XLEN'(1);
      if (retire)   instret_cnt <= instret_cnt + XLEN'(1);
    end
  end

endmodule

// File: rtl/core_ctrl.sv
// core_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I core.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   mem             : core_ctrl_if.master, imem/dmem request-acknowledge
//   opcode, funct3  : decoder fields of the instruction register
//   branch_taken    : ALU compare result for the current branch
//   ir_we, pc_we    : instruction register / PC load strobes
//   pc_sel          : next-PC select (pc_sel_e)
//   alu_src_a/b     : ALU operand selects
//   rf_we, wb_sel   : register file write strobe / writeback select (wb_sel_e)
//   halted, illegal : sticky stop indications (ecall/ebreak, bad opcode)
//   state           : current state, debug
//   cycle_cnt, instret_cnt : only when CORE_CTRL_PERF_EN is defined
// Optional feature macro: CORE_CTRL_PERF_EN (performance counters).
module core_ctrl
  import core_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  core_ctrl_if.master       mem,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic              branch_taken,
  output logic              ir_we,
  output logic              pc_we,
  output logic [1:0]        pc_sel,
  output logic              alu_src_a,
  output logic              alu_src_b,
  output logic              rf_we,
  output logic [1:0]        wb_sel,
  output logic              halted,
  output logic              illegal,
  output logic [2:0]        state
`ifdef CORE_CTRL_PERF_EN
  ,
  output logic [XLEN-1:0]   cycle_cnt,
  output logic [XLEN-1:0]   instret_cnt
`endif
);

  ctrl_state_e state_q;
  op_class_e   op_q;
  op_class_e   dec_cls;

  pc_sel_e     pc_sel_d;
  wb_sel_e     wb_sel_d;
  logic        imem_req_d;
  logic        dmem_req_d;
  logic        dmem_we_d;

  assign dec_cls = classify(opcode);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= CL_ILLEGAL;
    end else begin
      case (state_q)
        ST_IDLE:  state_q <= ST_FETCH;
        ST_FETCH: if (mem.imem_ack) state_q <= ST_DECODE;
        ST_DECODE: begin
          op_q <= dec_cls;
          case (dec_cls)
            CL_SYSTEM:  state_q <= (funct3 == 3'b000) ? ST_HALT : ST_TRAP;
            CL_ILLEGAL: state_q <= ST_TRAP;
            default:    state_q <= ST_EXEC;
          endcase
        end
        ST_EXEC: begin
          case (op_q)
            CL_BRANCH:         state_q <= ST_FETCH;
            CL_LOAD, CL_STORE: state_q <= ST_MEM;
            default:           state_q <= ST_WB;
          endcase
        end
        ST_MEM: if (mem.dmem_ack) state_q <= (op_q == CL_STORE) ? ST_FETCH : ST_WB;
        ST_WB:   state_q <= ST_FETCH;
        default: state_q <= state_q;   // HALT, TRAP absorb until reset
      endcase
    end
  end

  // Strobes that depend on ack/branch_taken must act in the same cycle, so
  // outputs are decoded combinationally from state_q/op_q rather than registered.
  always_comb begin
    imem_req_d = 1'b0;
    dmem_req_d = 1'b0;
    dmem_we_d  = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_sel_d   = PC_PLUS4;
    alu_src_a  = 1'b0;
    alu_src_b  = 1'b0;
    rf_we      = 1'b0;
    wb_sel_d   = WB_ALU;
    halted     = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      ST_FETCH: begin
        imem_req_d = 1'b1;
        ir_we      = mem.imem_ack;
      end
      ST_EXEC: begin
        alu_src_a = op_q inside {CL_AUIPC, CL_JAL, CL_BRANCH};
        alu_src_b = (op_q != CL_R);
        if (op_q == CL_BRANCH) begin
          pc_we = 1'b1;
          if (branch_taken) pc_sel_d = PC_REL;
        end
      end
      ST_MEM: begin
        dmem_req_d = 1'b1;
        dmem_we_d  = (op_q == CL_STORE);
        if (op_q == CL_STORE && mem.dmem_ack) pc_we = 1'b1;
      end
      ST_WB: begin
        rf_we = 1'b1;
        pc_we = 1'b1;
        case (op_q)
          CL_LOAD:         wb_sel_d = WB_MEM;
          CL_JAL, CL_JALR: wb_sel_d = WB_PC4;
          CL_LUI:          wb_sel_d = WB_IMM;
          default:         wb_sel_d = WB_ALU;
        endcase
        case (op_q)
          CL_JAL:  pc_sel_d = PC_REL;
          CL_JALR: pc_sel_d = PC_JALR;
          default: pc_sel_d = PC_PLUS4;
        endcase
      end
      ST_HALT: halted  = 1'b1;
      ST_TRAP: illegal = 1'b1;
      default: ;
    endcase
  end

  assign mem.imem_req = imem_req_d;
  assign mem.dmem_req = dmem_req_d;
  assign mem.dmem_we  = dmem_we_d;
  assign pc_sel       = pc_sel_d;
  assign wb_sel       = wb_sel_d;
  assign state        = state_q;

`ifdef CORE_CTRL_PERF_EN
  core_ctrl_perf #(
    .XLEN (XLEN)
  ) u_perf (
    .clk         (clk),
    .rst_n       (rst_n),
    .count_en    (!(state_q inside {ST_IDLE, ST_HALT, ST_TRAP})),
    .retire      (pc_we),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );
`endif

endmodule

// File: tb/tb_core_ctrl.sv
// tb_core_ctrl: directed test of core_ctrl. Inputs change 1 time unit after
// the rising edge; outputs are compared 1 time unit after that.
module tb_core_ctrl;
  import core_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       branch_taken;
  logic       ir_we, pc_we, alu_src_a, alu_src_b, rf_we, halted, illegal;
  logic [1:0] pc_sel, wb_sel;
  logic [2:0] state;
`ifdef CORE_CTRL_PERF_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  core_ctrl_if bus ();

  core_ctrl #(.XLEN(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem          (bus),
    .opcode       (opcode),
    .funct3       (funct3),
    .branch_taken (branch_taken),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .rf_we        (rf_we),
    .wb_sel       (wb_sel),
    .halted       (halted),
    .illegal      (illegal),
    .state        (state)
`ifdef CORE_CTRL_PERF_EN
    ,
    .cycle_cnt    (cycle_cnt),
    .instret_cnt  (instret_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // s = imem_req dmem_req dmem_we ir_we pc_we pc_sel[1:0] alu_a alu_b rf_we wb_sel[1:0] halted illegal
  task automatic exp_o(input string tag, input logic [2:0] st, input logic [13:0] s);
    logic [16:0] obs;
    logic [16:0] want;
    #1;
    obs  = {state, bus.imem_req, bus.dmem_req, bus.dmem_we, ir_we, pc_we, pc_sel,
            alu_src_a, alu_src_b, rf_we, wb_sel, halted, illegal};
    want = {st, s};
    checks++;
    assert (obs === want)
    else begin
      errors++;
      $error("FAIL %s: state/strobes got %b want %b", tag, obs, want);
    end
  endtask

`ifdef CORE_CTRL_PERF_EN
  task automatic exp_cnt(input string tag, input logic [31:0] cyc, input logic [31:0] ret);
    checks++;
    assert ({cycle_cnt, instret_cnt} === {cyc, ret})
    else begin
      errors++;
      $error("FAIL %s: cycle/instret got %0d/%0d want %0d/%0d", tag, cycle_cnt, instret_cnt, cyc, ret);
    end
  endtask
`endif

  // From FETCH with an immediate ack, through DECODE; leaves the DUT in the
  // state following DECODE.
  task automatic fetch(input string tag, input logic [6:0] op, input logic [2:0] f3);
    opcode = op;
    funct3 = f3;
    bus.imem_ack = 1'b1;
    exp_o({tag, "_fetch"}, 3'd1, 14'b1_0_0_1_0_00_0_0_0_00_0_0);
    tick();
    bus.imem_ack = 1'b0;
    exp_o({tag, "_decode"}, 3'd2, 14'b0);
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    opcode = 7'd0;
    funct3 = 3'd0;
    branch_taken = 1'b0;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    tick();
    tick();
    exp_o("reset", 3'd0, 14'b0);
`ifdef CORE_CTRL_PERF_EN
    exp_cnt("reset_cnt", 32'd0, 32'd0);
`endif
    rst_n = 1'b1;
    exp_o("release_idle", 3'd0, 14'b0);
    tick();

    // add: 0,1,2,3,5,1
    fetch("add", OP_R, 3'd0);
    exp_o("add_exec", 3'd3, 14'b0);
    tick();
    exp_o("add_wb", 3'd5, 14'b0_0_0_0_1_00_0_0_1_00_0_0);
    tick();
    exp_o("add_next", 3'd1, 14'b1_0_0_0_0_00_0_0_0_00_0_0);
`ifdef CORE_CTRL_PERF_EN
    exp_cnt("add_cnt", 32'd4, 32'd1);
`endif

    // lw with dmem_ack three cycles late
    fetch("lw", OP_LOAD, 3'd2);
    exp_o("lw_exec", 3'd3, 14'b0_0_0_0_0_00_0_1_0_00_0_0);
    tick();
    for (int i = 0; i < 3; i++) begin
      exp_o("lw_mem_wait", 3'd4, 14'b0_1_0_0_0_00_0_0_0_00_0_0);
      tick();
    end
    bus.dmem_ack = 1'b1;
    exp_o("lw_mem_ack", 3'd4, 14'b0_1_0_0_0_00_0_0_0_00_0_0);
    tick();
    bus.dmem_ack = 1'b0;
    exp_o("lw_wb", 3'd5, 14'b0_0_0_0_1_00_0_0_1_01_0_0);
    tick();

    // beq taken, with one cycle of fetch wait
    exp_o("beq_fetch_wait", 3'd1, 14'b1_0_0_0_0_00_0_0_0_00_0_0);
    tick();
    fetch("beq_t", OP_BRANCH, 3'd0);
    branch_taken = 1'b1;
    exp_o("beq_t_exec", 3'd3, 14'b0_0_0_0_1_01_1_1_0_00_0_0);
    tick();
    branch_taken = 1'b0;
    fetch("beq_nt", OP_BRANCH, 3'd0);
    exp_o("beq_nt_exec", 3'd3, 14'b0_0_0_0_1_00_1_1_0_00_0_0);
    tick();

    // jalr
    fetch("jalr", OP_JALR, 3'd0);
    exp_o("jalr_exec", 3'd3, 14'b0_0_0_0_0_00_0_1_0_00_0_0);
    tick();
    exp_o("jalr_wb", 3'd5, 14'b0_0_0_0_1_10_0_0_1_10_0_0);
    tick();

    // jal
    fetch("jal", OP_JAL, 3'd0);
    exp_o("jal_exec", 3'd3, 14'b0_0_0_0_0_00_1_1_0_00_0_0);
    tick();
    exp_o("jal_wb", 3'd5, 14'b0_0_0_0_1_01_0_0_1_10_0_0);
    tick();

    // lui, auipc
    fetch("lui", OP_LUI, 3'd0);
    exp_o("lui_exec", 3'd3, 14'b0_0_0_0_0_00_0_1_0_00_0_0);
    tick();
    exp_o("lui_wb", 3'd5, 14'b0_0_0_0_1_00_0_0_1_11_0_0);
    tick();
    fetch("auipc", OP_AUIPC, 3'd0);
    exp_o("auipc_exec", 3'd3, 14'b0_0_0_0_0_00_1_1_0_00_0_0);
    tick();
    exp_o("auipc_wb", 3'd5, 14'b0_0_0_0_1_00_0_0_1_00_0_0);
    tick();

    // sw with one cycle of ack delay
    fetch("sw", OP_STORE, 3'd2);
    exp_o("sw_exec", 3'd3, 14'b0_0_0_0_0_00_0_1_0_00_0_0);
    tick();
    exp_o("sw_mem_wait", 3'd4, 14'b0_1_1_0_0_00_0_0_0_00_0_0);
    tick();
    bus.dmem_ack = 1'b1;
    exp_o("sw_mem_ack", 3'd4, 14'b0_1_1_0_1_00_0_0_0_00_0_0);
    tick();
    bus.dmem_ack = 1'b0;
    exp_o("sw_next", 3'd1, 14'b1_0_0_0_0_00_0_0_0_00_0_0);

    // reset while a load waits in MEM
    fetch("lw_rst", OP_LOAD, 3'd2);
    tick();
    exp_o("lw_rst_mem", 3'd4, 14'b0_1_0_0_0_00_0_0_0_00_0_0);
    rst_n = 1'b0;
    tick();
    exp_o("mid_reset", 3'd0, 14'b0);
`ifdef CORE_CTRL_PERF_EN
    exp_cnt("mid_reset_cnt", 32'd0, 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    // AMO traps and ignores later acks
    fetch("amo", 7'b0101111, 3'd2);
    exp_o("amo_trap", 3'd7, 14'b0_0_0_0_0_00_0_0_0_00_0_1);
    bus.imem_ack = 1'b1;
    bus.dmem_ack = 1'b1;
    tick();
    tick();
    exp_o("amo_trap_stay", 3'd7, 14'b0_0_0_0_0_00_0_0_0_00_0_1);
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // csrrw (SYSTEM, funct3 != 0) traps
    fetch("csrrw", OP_SYSTEM, 3'd1);
    exp_o("csrrw_trap", 3'd7, 14'b0_0_0_0_0_00_0_0_0_00_0_1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // ebreak halts
    fetch("ebreak", OP_SYSTEM, 3'd0);
    exp_o("ebreak_halt", 3'd6, 14'b0_0_0_0_0_00_0_0_0_00_1_0);
    bus.imem_ack = 1'b1;
    tick();
    tick();
    exp_o("ebreak_halt_stay", 3'd6, 14'b0_0_0_0_0_00_0_0_0_00_1_0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_ctrl.md
# core_ctrl

Multi-cycle sequencing controller for the RV32I core. It drives the fetch → decode → execute → memory → writeback flow around the combinational instruction decoder, ALU, register file, PC register and the instruction and data memory ports. It consumes the decoder's `opcode`/`funct3` and the ALU branch result, and produces every enable and mux select for the datapath. It stops permanently on `ecall`/`ebreak` or on an illegal opcode, until reset.

## Interface
- `XLEN`, 32: datapath width (counter width when perf is enabled).
- `clk`  in  1  core clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `opcode`  in  7  from decoder (IR[6:0]).
- `funct3`  in  3  from decoder.
- `branch_taken`  in  1  ALU compare result for the current branch.
- `imem_req` / `imem_ack`  out / in  1 / 1  instruction fetch handshake.
- `dmem_req` / `dmem_ack`  out / in  1 / 1  data access handshake.
- `dmem_we`  out  1  1 = store.
- `ir_we`  out  1  load instruction register.
- `pc_we`  out  1  update PC.
- `pc_sel`  out  2  0 = pc+4, 1 = pc+imm, 2 = (rs1+imm)&~1.
- `alu_src_a`  out  1  0 = rs1, 1 = pc.
- `alu_src_b`  out  1  0 = rs2, 1 = imm.
- `rf_we`  out  1  register file write.
- `wb_sel`  out  2  0 = ALU, 1 = mem, 2 = pc+4, 3 = imm.
- `halted`  out  1  sticky, set on ecall/ebreak.
- `illegal`  out  1  sticky, set on unsupported opcode.
- `state`  out  3  current state, for debug.

## Operation
- States: IDLE = 0, FETCH = 1, DECODE = 2, EXEC = 3, MEM = 4, WB = 5, HALT = 6, TRAP = 7.
- All outputs are decoded from the state register and the latched class `op_q`. In IDLE, HALT and TRAP every strobe is 0.
- **IDLE** → FETCH, unconditionally.
- **FETCH**: `imem_req` = 1 until `imem_ack` is sampled high. In the ack cycle `ir_we` = 1, then → DECODE.
- **DECODE**: latch the opcode class into `op_q`.
  - SYSTEM (1110011) with `funct3` = 0 → HALT.
  - Any other SYSTEM, AMO (0101111) or an unlisted opcode → TRAP.
  - Otherwise → EXEC.
- **EXEC**:
  - `alu_src_a` = 1 for AUIPC, JAL and BRANCH; else 0.
  - `alu_src_b` = 0 only for R-type; else 1.
  - BRANCH: `pc_we` = 1, `pc_sel` = `branch_taken` ? 1 : 0, → FETCH.
  - LOAD/STORE → MEM.
  - Everything else → WB.
- **MEM**: `dmem_req` = 1 and `dmem_we` = STORE, held until `dmem_ack`.
  - In the ack cycle a STORE asserts `pc_we`, `pc_sel` = 0, then → FETCH.
  - A LOAD goes → WB.
- **WB**: `rf_we` = 1, `pc_we` = 1, then → FETCH.
  - `wb_sel`: LOAD = 1, JAL/JALR = 2, LUI = 3, otherwise 0.
  - `pc_sel`: JAL = 1, JALR = 2, otherwise 0.
- HALT and TRAP are absorbing. `halted` and `illegal` are 1 in them respectively.
- The ack inputs are ignored outside their own state.
- Writes to x0 are suppressed by the register file, not by this block.

## Timing
- Reset: on the first edge with `rst_n` = 0 the state becomes IDLE. All outputs are 0 (`state` = 0) while `rst_n` is low and for one cycle after release.
- Reset mid-transaction: `imem_req`/`dmem_req` drop at the reset edge. Memories must tolerate an abandoned request.
- Cycles per instruction, with ack in the first request cycle:
  - R/I-ALU, LUI, AUIPC, JAL, JALR: 4.
  - BRANCH: 3.
  - STORE: 4.
  - LOAD: 5.
- Each cycle of delayed ack adds one cycle and holds the request high.
- A request is never deasserted before its ack.
- `pc_we` and `rf_we` are single-cycle pulses per instruction.
- An ack arriving in the same cycle the request first rises is valid.

## Configuration
- `CORE_CTRL_PERF_EN` defined: adds outputs `cycle_cnt` and `instret_cnt`, each `XLEN` bits.
  - `cycle_cnt` counts every cycle outside IDLE, HALT and TRAP.
  - `instret_cnt` increments on each retiring `pc_we` pulse.
  - Both wrap modulo 2^XLEN and reset to 0.
- Undefined: neither port nor counter exists. Behaviour is otherwise identical.

## Structure
- Shared package `core_pkg`:
  - `ctrl_state_e` enum.
  - Opcode localparams (`OP_R`, `OP_IMM`, `OP_LOAD`, `OP_STORE`, `OP_BRANCH`, `OP_JAL`, `OP_JALR`, `OP_AUIPC`, `OP_LUI`, `OP_SYSTEM`).
  - `pc_sel_e` and `wb_sel_e` enums.
  - `op_class_e` enum.
- One sub-module, `core_ctrl_perf`, holds the two counters. It is instantiated only under `CORE_CTRL_PERF_EN`.

## Test plan
- Reset, then `add` (0110011) with immediate acks → states 0, 1, 2, 3, 5, 1. In WB: `rf_we` = 1, `wb_sel` = 0, `pc_sel` = 0.
- `lw` (0000011) with `dmem_ack` delayed 3 cycles → `dmem_req` high 4 cycles with `dmem_we` = 0, then WB with `wb_sel` = 1. Total 8 cycles.
- `beq` with `branch_taken` = 1 → `pc_we` pulse in EXEC with `pc_sel` = 1 and no `rf_we`. With `branch_taken` = 0 → `pc_sel` = 0.
- `jalr` → in WB: `wb_sel` = 2, `pc_sel` = 2. `sw` → `dmem_we` = 1, `pc_we` in the MEM ack cycle.
- Opcode 0101111 → TRAP, `illegal` = 1, and it stays there despite further acks. `ebreak` (0x00100073) → HALT, `halted` = 1.
- `rst_n` low during MEM with `dmem_req` high → next edge: `state` = 0 and all outputs 0. With `CORE_CTRL_PERF_EN`, both counters read 0.
